// File: rtl/dcim_ctrl_pkg.sv
// Shared types and constants for the SRAM multiplier sequencer.
package dcim_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic MODE_LOAD  = 1'b0;
  localparam logic MODE_RUN   = 1'b1;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int MULT_WIDTH     = 2 * DEF_DATA_WIDTH;

endpackage

// File: rtl/dcim_out_fifo.sv
// Synchronous output FIFO; a push into a full FIFO is accepted only alongside a pop.
module dcim_out_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               pop_data,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dcim_sram_mult_ctrl.sv
// Sequencer for the SRAM multiplier: LOAD writes weights, RUN multiplies operands by them.
// Define DCIM_ACC_EN to add a dot-product accumulator (acc_valid / acc_data).
module dcim_sram_mult_ctrl
  import dcim_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_COUNT = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid,
  input  logic                      cmd_mode,
  output logic                      cmd_ready,
  output logic                      cmd_err,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      in_ready,
  output logic                      sram_ce,
  output logic                      sram_we,
  output logic [ADDR_WIDTH-1:0]     sram_addr,
  output logic [DATA_WIDTH-1:0]     sram_wdata,
  input  logic [DATA_WIDTH-1:0]     sram_rdata,
  output logic                      out_valid,
  output logic [2*DATA_WIDTH-1:0]   out_data,
  input  logic                      out_ready,
  output logic                      init_done,
  output logic                      busy
`ifdef DCIM_ACC_EN
  ,
  output logic                      acc_valid,
  output logic [2*DATA_WIDTH+ADDR_WIDTH-1:0] acc_data
`endif
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   aligned;
  logic                    s1_valid;
  logic [PW-1:0]           product;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [CW:0]             credit_used;
  logic                    accept;
  logic                    last_addr;

  // The single in-flight stage (read issued, product not yet pushed) consumes a FIFO credit.
  assign credit_used = {1'b0, fifo_count} + (CW+1)'(s1_valid);

  always_comb begin
    in_ready = 1'b0;
    case (state)
      LOAD:    in_ready = 1'b1;
      RUN:     in_ready = (credit_used < (CW+1)'(FIFO_DEPTH));
      default: in_ready = 1'b0;
    endcase
  end

  assign accept     = in_valid && in_ready;
  assign last_addr  = (addr == ADDR_WIDTH'(ADDR_COUNT - 1));
  assign sram_ce    = accept;
  assign sram_we    = accept && (state == LOAD);
  assign sram_addr  = addr;
  assign sram_wdata = (state == LOAD) ? in_data : '0;
  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign product    = PW'(sram_rdata) * PW'(aligned);
  assign out_valid  = !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      init_done <= 1'b0;
      cmd_err   <= 1'b0;
      s1_valid  <= 1'b0;
      aligned   <= '0;
    end else begin
      cmd_err  <= 1'b0;
      s1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_mode == MODE_LOAD) begin
              state     <= LOAD;
              init_done <= 1'b0;
              addr      <= '0;
            end else if (init_done) begin
              state <= RUN;
              addr  <= '0;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            if (last_addr) begin
              addr      <= '0;
              init_done <= 1'b1;
              state     <= IDLE;
            end else begin
              addr <= addr + ADDR_WIDTH'(1);
            end
          end
        end
        RUN: begin
          if (accept) begin
            aligned  <= in_data;
            s1_valid <= 1'b1;
            if (last_addr) begin
              addr  <= '0;
              state <= DRAIN;
            end else begin
              addr <= addr + ADDR_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (!s1_valid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The FIFO entry serves as the registered product stage, so out_valid rises two cycles after accept.
  dcim_out_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (s1_valid),
    .push_data (product),
    .pop       (out_ready),
    .pop_data  (out_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

`ifdef DCIM_ACC_EN
  // acc_valid is registered off the DRAIN exit, when the last product has already been summed.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_valid <= 1'b0;
      acc_data  <= '0;
    end else begin
      acc_valid <= (state == DRAIN) && !s1_valid;
      if ((state == IDLE) && cmd_valid && (cmd_mode == MODE_RUN) && init_done) begin
        acc_data <= '0;
      end else if (s1_valid) begin
        acc_data <= acc_data + (2*DATA_WIDTH+ADDR_WIDTH)'(product);
      end else begin
        acc_data <= acc_data;
      end
    end
  end
`endif

endmodule
